coin_collector: RTL and testbench

- Front-end stage directly upstream of the vending machine core.
- Accepts coins one at a time from the coin slot and accumulates a per-denomination count.
- On an item selection, hands the batch (2-bit count per denomination plus item type) to the core during a `SERVICE_ON` cycle, then holds off until the core finishes its transaction.
- Returns coins on cancel or inactivity timeout via a refund port.

---
 rtl/vending_pkg.sv | 39 +++
 rtl/coin_collector_if.sv | 41 ++++
 rtl/coin_counter_sat.sv | 26 ++
 rtl/coin_collector.sv | 127 ++++++++++++
 tb/tb_coin_collector.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine: service/coin/item codes, coin values,
// collector state encoding and the held-value helper.
package vending_pkg;

    localparam logic [1:0] SERVICE_OFF  = 2'b00;
    localparam logic [1:0] SERVICE_ON   = 2'b01;
    localparam logic [1:0] SERVICE_BUSY = 2'b10;

    localparam logic [1:0] NTD_50 = 2'b00;
    localparam logic [1:0] NTD_10 = 2'b01;
    localparam logic [1:0] NTD_5  = 2'b10;
    localparam logic [1:0] NTD_1  = 2'b11;

    localparam logic [7:0] COIN_VAL_50 = 8'd50;
    localparam logic [7:0] COIN_VAL_10 = 8'd10;
    localparam logic [7:0] COIN_VAL_5  = 8'd5;
    localparam logic [7:0] COIN_VAL_1  = 8'd1;

    localparam logic [1:0] ITEM_NONE = 2'b00;
    localparam logic [1:0] ITEM_A    = 2'b01;
    localparam logic [1:0] ITEM_B    = 2'b10;
    localparam logic [1:0] ITEM_C    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StIssue,
        StWaitDone,
        StRefund
    } collector_state_e;

    // Counts saturate at 3, so the sum tops out at 198 and fits in 8 bits.
    function automatic logic [7:0] coin_value(input logic [1:0] c50, input logic [1:0] c10,
                                              input logic [1:0] c5, input logic [1:0] c1);
        return (8'(c50) * COIN_VAL_50) + (8'(c10) * COIN_VAL_10) +
               (8'(c5) * COIN_VAL_5) + (8'(c1) * COIN_VAL_1);
    endfunction

endpackage

// File: rtl/coin_collector_if.sv
// Coin slot / item select / core handoff / refund bundle of the coin collector.
// The collector is the slave; the environment (slot, keypad, core) is the master.
interface coin_collector_if;
    import vending_pkg::*;

    logic       coinValid;
    logic [1:0] coinType;
    logic       itemSelValid;
    logic [1:0] itemSel;
    logic       cancel;
    logic [1:0] serviceTypeIn;
    logic [1:0] coinInNTD_50;
    logic [1:0] coinInNTD_10;
    logic [1:0] coinInNTD_5;
    logic [1:0] coinInNTD_1;
    logic [1:0] itemTypeIn;
    logic       coinAccept;
    logic       coinReject;
    logic       refundValid;
    logic [1:0] refundNTD_50;
    logic [1:0] refundNTD_10;
    logic [1:0] refundNTD_5;
    logic [1:0] refundNTD_1;
    logic [7:0] pendingValue;
    logic       busy;

    modport master (
        output coinValid, coinType, itemSelValid, itemSel, cancel, serviceTypeIn,
        input  coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn,
        input  coinAccept, coinReject, refundValid,
        input  refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1, pendingValue, busy
    );

    modport slave (
        input  coinValid, coinType, itemSelValid, itemSel, cancel, serviceTypeIn,
        output coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn,
        output coinAccept, coinReject, refundValid,
        output refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1, pendingValue, busy
    );

endinterface

// File: rtl/coin_counter_sat.sv
// 2-bit saturating counter: holds at 3, synchronous clear wins over increment.
module coin_counter_sat (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [1:0] o_count,
    output logic       o_full
);

    logic [1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
        end else if (i_clr) begin
            r_count <= 2'd0;
        end else if (i_inc && !o_full) begin
            r_count <= r_count + 2'd1;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == 2'd3);

endmodule

// File: rtl/coin_collector.sv
// Coin collector front end: counts coins per denomination, hands the batch to the core
// on item selection, and refunds on cancel or inactivity timeout.
module coin_collector
    import vending_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TMR_W          = 8
) (
    input logic             clk,
    input logic             reset,
    coin_collector_if.slave io_bus
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    collector_state_e r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [1:0]       r_item, w_item_nxt;
    logic             r_coin_accept, r_coin_reject;

    logic [1:0] w_cnt [4];
    logic [3:0] w_full;
    logic [3:0] w_inc;
    logic       w_open, w_accept, w_reject, w_sel, w_handoff, w_clr, w_refund;

    assign w_open    = (r_state == StIdle) || (r_state == StCollect);
    assign w_accept  = io_bus.coinValid && w_open && !w_full[io_bus.coinType];
    assign w_reject  = io_bus.coinValid && !w_accept;
    assign w_sel     = io_bus.itemSelValid && (io_bus.itemSel != ITEM_NONE);
    assign w_handoff = (r_state == StIssue) && (io_bus.serviceTypeIn == SERVICE_ON);
    assign w_refund  = (r_state == StRefund);
    assign w_clr     = w_handoff || w_refund;

    // Counter index equals the coin type code (0=NTD50 .. 3=NTD1).
    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign w_inc[g] = w_accept && (io_bus.coinType == 2'(g));
        coin_counter_sat u_cnt (
            .clk    (clk),
            .reset  (reset),
            .i_inc  (w_inc[g]),
            .i_clr  (w_clr),
            .o_count(w_cnt[g]),
            .o_full (w_full[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_timer       <= '0;
            r_item        <= ITEM_NONE;
            r_coin_accept <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_item        <= w_item_nxt;
            r_coin_accept <= w_accept;
            r_coin_reject <= w_reject;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        w_item_nxt  = ITEM_NONE;
        case (r_state)
            StIdle: begin
                if (w_sel) begin
                    w_state_nxt = StIssue;
                end else if (w_accept) begin
                    w_state_nxt = StCollect;
                end
            end
            StCollect: begin
                if (!w_accept && (r_timer != TMR_LAST)) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
                // Cancel outranks selection; timeout only fires on an otherwise quiet cycle.
                if (io_bus.cancel) begin
                    w_state_nxt = StRefund;
                end else if (w_sel) begin
                    w_state_nxt = StIssue;
                end else if (!w_accept && (r_timer == TMR_LAST)) begin
                    w_state_nxt = StRefund;
                end
            end
            StIssue: begin
                if (w_handoff) begin
                    w_state_nxt = StWaitDone;
                end else if (io_bus.cancel) begin
                    w_state_nxt = StRefund;
                end
            end
            StWaitDone: begin
                if (io_bus.serviceTypeIn == SERVICE_OFF) begin
                    w_state_nxt = StIdle;
                end
            end
            StRefund: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        if (w_state_nxt == StIssue) begin
            w_item_nxt = (r_state == StIssue) ? r_item : io_bus.itemSel;
        end
    end

    assign io_bus.coinInNTD_50 = w_cnt[0];
    assign io_bus.coinInNTD_10 = w_cnt[1];
    assign io_bus.coinInNTD_5  = w_cnt[2];
    assign io_bus.coinInNTD_1  = w_cnt[3];
    assign io_bus.itemTypeIn   = r_item;
    assign io_bus.coinAccept   = r_coin_accept;
    assign io_bus.coinReject   = r_coin_reject;
    assign io_bus.refundValid  = w_refund;
    assign io_bus.refundNTD_50 = w_refund ? w_cnt[0] : 2'b00;
    assign io_bus.refundNTD_10 = w_refund ? w_cnt[1] : 2'b00;
    assign io_bus.refundNTD_5  = w_refund ? w_cnt[2] : 2'b00;
    assign io_bus.refundNTD_1  = w_refund ? w_cnt[3] : 2'b00;
    assign io_bus.pendingValue = coin_value(w_cnt[0], w_cnt[1], w_cnt[2], w_cnt[3]);
    assign io_bus.busy         = (r_state == StIssue) || (r_state == StWaitDone) || w_refund;

endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector with a short (4-cycle) inactivity timeout.
module tb_coin_collector;
    import vending_pkg::*;

    logic        clk;
    logic        reset;
    int unsigned n_vec;
    int unsigned n_err;

    coin_collector_if bus ();

    coin_collector #(
        .TIMEOUT_CYCLES(4),
        .TMR_W         (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.coinValid    = 1'b0;
        bus.coinType     = 2'b00;
        bus.itemSelValid = 1'b0;
        bus.itemSel      = ITEM_NONE;
        bus.cancel       = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] t);
        bus.coinValid = 1'b1;
        bus.coinType  = t;
        tick();
        bus.coinValid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        quiet();
        bus.serviceTypeIn = SERVICE_OFF;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pending", 32'(bus.pendingValue), 0);
        chk("rst_accept", 32'(bus.coinAccept), 0);
        chk("rst_reject", 32'(bus.coinReject), 0);
        chk("rst_refund", 32'(bus.refundValid), 0);
        chk("rst_item", 32'(bus.itemTypeIn), 0);
        chk("rst_c50", 32'(bus.coinInNTD_50), 0);
        reset = 1'b0;

        // 1: batch handoff 10,10,5,1 then item A
        put_coin(NTD_10);
        chk("t1_acc1", 32'(bus.coinAccept), 1);
        chk("t1_pv10", 32'(bus.pendingValue), 10);
        put_coin(NTD_10);
        chk("t1_pv20", 32'(bus.pendingValue), 20);
        put_coin(NTD_5);
        chk("t1_pv25", 32'(bus.pendingValue), 25);
        put_coin(NTD_1);
        chk("t1_acc4", 32'(bus.coinAccept), 1);
        chk("t1_pv26", 32'(bus.pendingValue), 26);
        bus.itemSelValid  = 1'b1;
        bus.itemSel       = ITEM_A;
        bus.serviceTypeIn = SERVICE_ON;
        tick();
        bus.itemSelValid = 1'b0;
        bus.itemSel      = ITEM_NONE;
        chk("t1_iss_item", 32'(bus.itemTypeIn), 1);
        chk("t1_iss_c10", 32'(bus.coinInNTD_10), 2);
        chk("t1_iss_c5", 32'(bus.coinInNTD_5), 1);
        chk("t1_iss_c1", 32'(bus.coinInNTD_1), 1);
        chk("t1_iss_c50", 32'(bus.coinInNTD_50), 0);
        chk("t1_iss_busy", 32'(bus.busy), 1);
        chk("t1_iss_acc", 32'(bus.coinAccept), 0);
        tick();
        chk("t1_wd_item", 32'(bus.itemTypeIn), 0);
        chk("t1_wd_c10", 32'(bus.coinInNTD_10), 0);
        chk("t1_wd_pv", 32'(bus.pendingValue), 0);
        chk("t1_wd_busy", 32'(bus.busy), 1);
        bus.serviceTypeIn = SERVICE_OFF;
        tick();
        chk("t1_idle_busy", 32'(bus.busy), 0);

        // 2: saturation on four NTD50
        put_coin(NTD_50);
        chk("t2_acc1", 32'(bus.coinAccept), 1);
        put_coin(NTD_50);
        chk("t2_acc2", 32'(bus.coinAccept), 1);
        put_coin(NTD_50);
        chk("t2_acc3", 32'(bus.coinAccept), 1);
        chk("t2_pv150a", 32'(bus.pendingValue), 150);
        put_coin(NTD_50);
        chk("t2_rej4", 32'(bus.coinReject), 1);
        chk("t2_noacc4", 32'(bus.coinAccept), 0);
        chk("t2_c50", 32'(bus.coinInNTD_50), 3);
        chk("t2_pv150b", 32'(bus.pendingValue), 150);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("t2_rv", 32'(bus.refundValid), 1);
        chk("t2_r50", 32'(bus.refundNTD_50), 3);
        tick();
        chk("t2_rv_off", 32'(bus.refundValid), 0);

        // 3: cancel refund of 50 + 1
        put_coin(NTD_50);
        put_coin(NTD_1);
        chk("t3_pv51", 32'(bus.pendingValue), 51);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("t3_rv", 32'(bus.refundValid), 1);
        chk("t3_r50", 32'(bus.refundNTD_50), 1);
        chk("t3_r1", 32'(bus.refundNTD_1), 1);
        chk("t3_r10", 32'(bus.refundNTD_10), 0);
        chk("t3_busy", 32'(bus.busy), 1);
        tick();
        chk("t3_rv_off", 32'(bus.refundValid), 0);
        chk("t3_r50_off", 32'(bus.refundNTD_50), 0);
        chk("t3_pv0", 32'(bus.pendingValue), 0);
        chk("t3_c50", 32'(bus.coinInNTD_50), 0);
        chk("t3_idle", 32'(bus.busy), 0);

        // 4: timeout fires 4 cycles after the accept
        put_coin(NTD_5);
        chk("t4_acc", 32'(bus.coinAccept), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_wait", 32'(bus.refundValid), 0);
        end
        tick();
        chk("t4_rv", 32'(bus.refundValid), 1);
        chk("t4_r5", 32'(bus.refundNTD_5), 1);
        tick();
        chk("t4_rv_off", 32'(bus.refundValid), 0);
        put_coin(NTD_5);
        tick();
        put_coin(NTD_5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_restart_wait", 32'(bus.refundValid), 0);
        end
        tick();
        chk("t4_restart_rv", 32'(bus.refundValid), 1);
        chk("t4_restart_r5", 32'(bus.refundNTD_5), 2);
        tick();

        // 5: ISSUE blocked by BUSY core, coin rejected, cancel refunds
        put_coin(NTD_10);
        bus.itemSelValid  = 1'b1;
        bus.itemSel       = ITEM_B;
        bus.serviceTypeIn = SERVICE_BUSY;
        tick();
        bus.itemSelValid = 1'b0;
        bus.itemSel      = ITEM_NONE;
        chk("t5_item", 32'(bus.itemTypeIn), 2);
        put_coin(NTD_10);
        chk("t5_rej", 32'(bus.coinReject), 1);
        chk("t5_c10", 32'(bus.coinInNTD_10), 1);
        tick();
        chk("t5_hold_item", 32'(bus.itemTypeIn), 2);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("t5_rv", 32'(bus.refundValid), 1);
        chk("t5_r10", 32'(bus.refundNTD_10), 1);
        chk("t5_item_off", 32'(bus.itemTypeIn), 0);
        tick();
        // handoff beats a same-cycle cancel; WAIT_DONE ignores coin and cancel
        put_coin(NTD_1);
        bus.itemSelValid = 1'b1;
        bus.itemSel      = ITEM_C;
        tick();
        bus.itemSelValid = 1'b0;
        bus.itemSel      = ITEM_NONE;
        chk("t5_item_c", 32'(bus.itemTypeIn), 3);
        bus.serviceTypeIn = SERVICE_ON;
        bus.cancel        = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("t5_ho_rv", 32'(bus.refundValid), 0);
        chk("t5_ho_c1", 32'(bus.coinInNTD_1), 0);
        chk("t5_ho_busy", 32'(bus.busy), 1);
        bus.serviceTypeIn = SERVICE_BUSY;
        bus.coinValid     = 1'b1;
        bus.coinType      = NTD_1;
        bus.cancel        = 1'b1;
        tick();
        quiet();
        chk("t5_wd_rej", 32'(bus.coinReject), 1);
        chk("t5_wd_rv", 32'(bus.refundValid), 0);
        chk("t5_wd_c1", 32'(bus.coinInNTD_1), 0);
        tick();
        chk("t5_wd_busy", 32'(bus.busy), 1);
        chk("t5_wd_rv2", 32'(bus.refundValid), 0);
        bus.serviceTypeIn = SERVICE_OFF;
        tick();
        chk("t5_idle", 32'(bus.busy), 0);

        // 6: reset in ISSUE drops everything without a refund
        put_coin(NTD_50);
        bus.itemSelValid  = 1'b1;
        bus.itemSel       = ITEM_A;
        bus.serviceTypeIn = SERVICE_BUSY;
        tick();
        quiet();
        chk("t6_issue", 32'(bus.itemTypeIn), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_item", 32'(bus.itemTypeIn), 0);
        chk("t6_c50", 32'(bus.coinInNTD_50), 0);
        chk("t6_pv", 32'(bus.pendingValue), 0);
        chk("t6_rv", 32'(bus.refundValid), 0);
        chk("t6_acc", 32'(bus.coinAccept), 0);
        tick();
        chk("t6_rv_after", 32'(bus.refundValid), 0);
        chk("t6_busy_after", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
